// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA read engine: FSM state encoding and
// the default cache-line address/count widths.
package dma_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned CL_BYTE_INDEX_BITS = 6;

  // Default widths; counters carry one extra bit so a full 2^ADDR_W transfer fits.
  localparam int unsigned ADDR_W = 42;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   count_t;

endpackage

// File: rtl/dma_fifo.sv
// Response buffer for the DMA read engine: synchronous FIFO with registered
// empty flag and occupancy count. Storage is deliberately not reset.
module dma_fifo #(
  parameter int unsigned Width = 512,
  parameter int unsigned Depth = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             empty_q;
  logic             do_pop;

  // A pop against an empty buffer is ignored; callers never see a bypassed push.
  assign do_pop = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (push_i && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push_i && do_pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/dma_rd_engine.sv
// Credit-based cache-line read engine feeding an in-order response FIFO.
// Define DMA_RD_ENGINE_PERF_CNT_EN to build the rd_cycles busy-cycle counter.
module dma_rd_engine
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 42,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_go,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [ADDR_WIDTH:0]   rd_size,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  rd_done,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_stall,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic [31:0]           rd_cycles
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam int unsigned SumW = CntW + 1;
  localparam int unsigned OccW = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CntW-1:0]       size_q, issued_q, outstanding_q, popped_q;
  logic                  rd_done_q;
  logic [OccW-1:0]       occupancy;
  logic                  fifo_empty;
  logic                  go_ok, credit_ok, issue, rsp_wr, pop;

  assign go_ok     = rd_go && ((state_q == StIdle) || (state_q == StDone));
  // Every line in flight or buffered holds a credit, so responses always fit.
  assign credit_ok = (({1'b0, outstanding_q} + SumW'(occupancy)) < SumW'(FIFO_DEPTH));
  assign issue     = (state_q == StIssue) && !mem_req_stall && credit_ok &&
                     (issued_q != size_q);
  // Late responses from an aborted transfer land while idle and are dropped.
  assign rsp_wr    = mem_rsp_valid && (state_q != StIdle);
  assign pop       = rd_en && !fifo_empty;

  assign mem_req_valid = issue;
  assign mem_req_addr  = base_q + issued_q[ADDR_WIDTH-1:0];
  assign empty         = fifo_empty;
  assign rd_done       = rd_done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      base_q        <= '0;
      size_q        <= '0;
      issued_q      <= '0;
      outstanding_q <= '0;
      popped_q      <= '0;
      rd_done_q     <= 1'b0;
    end else begin
      if (issue) begin
        issued_q <= issued_q + CntW'(1);
      end
      if (issue && !rsp_wr) begin
        outstanding_q <= outstanding_q + CntW'(1);
      end else if (!issue && rsp_wr) begin
        outstanding_q <= outstanding_q - CntW'(1);
      end
      if (pop) begin
        popped_q <= popped_q + CntW'(1);
      end
      rd_done_q <= (state_q == StDone);

      unique case (state_q)
        StIdle, StDone: begin
          if (go_ok) begin
            base_q        <= rd_addr;
            size_q        <= rd_size;
            issued_q      <= '0;
            outstanding_q <= '0;
            popped_q      <= '0;
            rd_done_q     <= 1'b0;
            state_q       <= (rd_size == '0) ? StDone : StIssue;
          end
        end
        StIssue: begin
          if (issue && ((issued_q + CntW'(1)) == size_q)) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && ((popped_q + CntW'(1)) == size_q)) begin
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DMA_RD_ENGINE_PERF_CNT_EN
  logic [31:0] rd_cycles_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cycles_q <= '0;
    end else if (go_ok) begin
      rd_cycles_q <= '0;
    end else if (((state_q == StIssue) || (state_q == StDrain)) && (rd_cycles_q != '1)) begin
      rd_cycles_q <= rd_cycles_q + 32'd1;
    end
  end

  assign rd_cycles = rd_cycles_q;
`else
  assign rd_cycles = '0;
`endif

  dma_fifo #(
    .Width (DATA_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (rsp_wr),
    .data_i  (mem_rsp_data),
    .pop_i   (pop),
    .data_o  (rd_data),
    .empty_o (fifo_empty),
    .count_o (occupancy)
  );

endmodule

// File: tb/tb_dma_rd_engine.sv
// Directed plus randomized bench for dma_rd_engine with an in-order memory
// model and a transaction-level reference of requests, pops and completion.
module tb_dma_rd_engine;

  localparam int unsigned AW = 42;
  localparam int unsigned DW = 64;
  localparam int unsigned FifoDepth = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_go;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_size;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          rd_done;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_stall;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic [31:0]   rd_cycles;

  dma_rd_engine #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FifoDepth)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rd_go         (rd_go),
    .rd_addr       (rd_addr),
    .rd_size       (rd_size),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .empty         (empty),
    .rd_done       (rd_done),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_stall (mem_req_stall),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .rd_cycles     (rd_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Stimulus controls
  int          cyc = 0;
  logic        rst_val = 1'b0;
  int          stall_mode = 0;  // 0 never, 1 alternate cycles, 2 random
  int          ren_mode = 1;    // 0 off, 1 on, 2 random
  int          lat_mode = 2;    // 0 random 1..4, otherwise fixed latency
  bit          go_req = 1'b0;
  bit          noise_go = 1'b0;
  logic [AW-1:0] go_addr;
  logic [AW:0]   go_size;

  // Reference model state
  bit            tb_active = 1'b0;
  logic [AW-1:0] tb_base = '0;
  longint        tb_size = 0;
  longint        req_count = 0;
  longint        pop_count = 0;
  longint        deliv_count = 0;
  int            done_cycle = -1;
  bit            busy = 1'b0;
  longint        exp_cyc = 0;
  logic [AW-1:0] pend_addr[$];
  int            pend_due[$];

  function automatic logic [DW-1:0] line_data(input logic [AW-1:0] a);
    return ({22'h0, a} * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit delivered;
    bit pop;
    bit in_rst;
    longint occ;
    int lat;
    logic [AW-1:0] exp_addr;
    @(negedge clk);
    cyc++;
    rst = rst_val;
    rd_go   = go_req || noise_go;
    rd_addr = go_req ? go_addr : 42'h3FF_FFFF_0000;
    rd_size = go_req ? go_size : 43'd7;
    case (stall_mode)
      0:       mem_req_stall = 1'b0;
      1:       mem_req_stall = cyc[0];
      default: mem_req_stall = 1'($urandom_range(0, 1));
    endcase
    case (ren_mode)
      0:       rd_en = 1'b0;
      1:       rd_en = 1'b1;
      default: rd_en = 1'($urandom_range(0, 1));
    endcase
    delivered = 1'b0;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = line_data(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
      delivered = 1'b1;
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = {$urandom(), $urandom()};
    end
    #1;
    in_rst = !rst_val;
    if (in_rst) begin
      tb_active = 1'b0; busy = 1'b0; exp_cyc = 0;
      req_count = 0; pop_count = 0; deliv_count = 0; done_cycle = -1;
      check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    end
    occ = deliv_count - pop_count;
    check("stall_valid", 64'(mem_req_valid && mem_req_stall), 64'd0);
    check("empty", 64'(empty), 64'(occ == 0));
    check("rd_done", 64'(rd_done), 64'(tb_active && done_cycle >= 0 && cyc >= done_cycle + 2));
`ifdef DMA_RD_ENGINE_PERF_CNT_EN
    check("rd_cycles", 64'(rd_cycles), 64'(exp_cyc));
`else
    check("rd_cycles", 64'(rd_cycles), 64'd0);
`endif
    if (mem_req_valid) begin
      check("req_allowed", 64'(tb_active && req_count < tb_size && !go_req), 64'd1);
      exp_addr = AW'(tb_base + AW'(req_count));
      check("req_addr", 64'(mem_req_addr), 64'(exp_addr));
      lat = (lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode;
      pend_addr.push_back(mem_req_addr);
      pend_due.push_back(cyc + lat);
      req_count++;
    end
    check("inflight", 64'(req_count - pop_count <= longint'(FifoDepth)), 64'd1);
    pop = rd_en && (occ > 0);
    if (pop) begin
      check("rd_data", rd_data, line_data(AW'(tb_base + AW'(pop_count))));
      pop_count++;
      if (pop_count == tb_size) done_cycle = cyc;
    end
    if (delivered && tb_active && !in_rst) deliv_count++;
    if (go_req) begin
      exp_cyc = 0;
      busy = (go_size != 0);
      tb_base = go_addr;
      tb_size = longint'(go_size);
      req_count = 0; pop_count = 0; deliv_count = 0;
      tb_active = 1'b1;
      done_cycle = (go_size == 0) ? cyc : -1;
      go_req = 1'b0;
    end else if (busy) begin
      exp_cyc++;
      if (pop && pop_count == tb_size) busy = 1'b0;
    end
  endtask

  task automatic start(input logic [AW-1:0] a, input logic [AW:0] s);
    go_addr = a;
    go_size = s;
    go_req  = 1'b1;
    tick();
  endtask

  task automatic finish_xfer(input string tag, input int budget);
    int n = 0;
    while (!(done_cycle >= 0 && cyc >= done_cycle + 1) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 64'(n < budget), 64'd1);
    tick();
    check({tag, "_rd_done"}, 64'(rd_done), 64'd1);
    check({tag, "_reqs"}, 64'(req_count), 64'(tb_size));
    check({tag, "_pops"}, 64'(pop_count), 64'(tb_size));
  endtask

  initial begin
    int n;
    rst = 1'b0; rd_go = 1'b0; rd_addr = '0; rd_size = '0; rd_en = 1'b0;
    mem_req_stall = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;

    // Reset state
    rst_val = 1'b0;
    repeat (3) tick();
    rst_val = 1'b1;
    repeat (2) tick();

    // Basic transfer, fixed 2-cycle latency, consumer always ready
    lat_mode = 2; stall_mode = 0; ren_mode = 1;
    start(42'h100, 43'd4);
    finish_xfer("basic", 100);

    // Backpressure: consumer stalled, credits must cap requests at the depth
    lat_mode = 0; ren_mode = 0;
    start(42'h4000, 43'd20);
    repeat (40) tick();
    check("bp_reqs_capped", 64'(req_count), 64'(FifoDepth));
    ren_mode = 1;
    finish_xfer("bp", 400);

    // Alternating stall, plus a stray rd_go that must be ignored mid-transfer
    stall_mode = 1; ren_mode = 2;
    start(42'h800, 43'd5);
    repeat (2) tick();
    noise_go = 1'b1;
    tick();
    noise_go = 1'b0;
    finish_xfer("stall", 200);
    stall_mode = 0;

    // Zero-size transfer
    ren_mode = 1;
    start(42'h55, 43'd0);
    finish_xfer("zero", 20);

    // Address wrap
    start(42'h3FF_FFFF_FFFE, 43'd4);
    finish_xfer("wrap", 100);

    // Abort mid-transfer, stale responses dropped, clean restart
    lat_mode = 3; ren_mode = 0;
    start(42'h2000, 43'd10);
    n = 0;
    while (req_count < 3 && n < 50) begin tick(); n++; end
    check("abort_reached3", 64'(req_count), 64'd3);
    rst_val = 1'b0;
    repeat (2) tick();
    rst_val = 1'b1;
    n = 0;
    while (pend_due.size() > 0 && n < 20) begin tick(); n++; end
    repeat (2) tick();
    check("abort_idle_empty", 64'(empty), 64'd1);
    ren_mode = 1; lat_mode = 0;
    start(42'h3000, 43'd2);
    finish_xfer("abort", 100);

    // Randomized transfers
    stall_mode = 2; ren_mode = 2; lat_mode = 0;
    repeat (6) begin
      start(AW'({$urandom(), $urandom()}), 43'($urandom_range(1, 30)));
      finish_xfer("rand", 2000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
